timer_bus_arbiter: RTL and testbench
====================================

Name: timer_bus_arbiter

Overview:
Peripheral-bus controller that shares the two on-chip timer register ports between two bus masters. Master 0 is the CPU load/store path. Master 1 is the secondary master (debug/DMA port). The block arbitrates requests round-robin, decodes each address to timer 0, timer 1 or unmapped, sequences one register access per grant, and returns registered read data with a one-cycle ack. It also registers the timer IRQ lines into the HWInt vector consumed by CP0.

Parameters:
BASE0, 32'h0000_7F00, timer 0 base; match on addr[31:4].
BASE1, 32'h0000_7F10, timer 1 base; match on addr[31:4].

Ports:
Clock  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
m0_req  in  1  master 0 request, held until m0_ack
m0_addr  in  32  master 0 byte address
m0_we  in  1  master 0 write (1) / read (0)
m0_wd  in  32  master 0 write data
m0_rdata  out  32  master 0 read data, valid while m0_ack
m0_ack  out  1  master 0 completion pulse
m1_req, m1_addr, m1_we, m1_wd, m1_rdata, m1_ack  same widths and meaning, master 1
t0_addr  out  2  timer 0 register select (Addr[3:2])
t0_we  out  1  timer 0 write enable
t0_wd  out  32  timer 0 write data
t0_rd  in  32  timer 0 read data (combinational)
t0_irq  in  1  timer 0 IRQ
t1_addr, t1_we, t1_wd, t1_rd, t1_irq  same, timer 1
HWInt  out  6  interrupt vector to CP0: bit0=t0_irq, bit1=t1_irq, bits5:2=0

Behaviour:
- FSM states: IDLE, XFER, RESP. Requests are sampled only in IDLE.
- IDLE:
  - If only one req is high, grant that master.
  - If both are high, grant the master not granted last (last_grant).
  - On grant, latch addr, we, wd and grant id, then go to XFER. With no req, stay in IDLE.
- XFER (exactly 1 cycle):
  - Drive the selected timer with tX_addr = latched addr[3:2], tX_wd = latched wd.
  - tX_we = latched we, only on an address hit and addr[3:2] != 3.
  - Capture read data into rdata_reg: tX_rd on a hit with offset 0..2, otherwise 32'h0.
  - Go to RESP.
- RESP (1 cycle):
  - Assert ack of the granted master only; its rdata = rdata_reg.
  - Update last_grant to the granted id, then go to IDLE.
- Latency: req seen in IDLE at edge n produces ack high during cycle n+2. Back-to-back throughput is one access per 3 cycles.
- Non-granted master: ack=0, rdata=0. Its req stays pending and is served at the next IDLE.
- Decode:
  - addr[31:4]==BASE0[31:4] selects timer 0; ==BASE1[31:4] selects timer 1; anything else is unmapped.
  - Unmapped write: no tX_we. Unmapped read: returns 0. Ack is still issued.
  - addr[1:0] is ignored.
- Timer outputs outside XFER: tX_addr=0, tX_wd=0, tX_we=0. At most one tX_we is high in any cycle.
- If req drops after grant, the latched transaction still completes and ack is still pulsed.
- HWInt is registered: HWInt[1:0] <= {t1_irq, t0_irq} every cycle, giving 1-cycle latency. It is independent of the FSM.
- Reset (any state, including mid-XFER):
  - Next edge: state=IDLE, last_grant=1 (master 0 wins the first tie).
  - m0_ack=m1_ack=0, rdata_reg=0, HWInt=0.
  - All tX_we=0. No write is issued in the reset cycle.
- Reads have no side effects. Writes reach the timer exactly once per transaction.

Test Plan:
- m0 writes 32'd100 to 0x7F04: t0_we=1, t0_addr=1, t0_wd=100 for exactly one cycle (XFER). m0_ack is pulsed 2 cycles after req. A subsequent m0 read of 0x7F04 returns 100.
- m0 and m1 both request from Reset (m0 reads 0x7F00, m1 reads 0x7F18):
  - m0 is served first (ack at n+2); m1 is served next (ack at n+5).
  - With both held high, grants then alternate m0, m1, m0.
- m1 writes 0xDEAD to 0x7F20 (unmapped): no t0_we/t1_we, m1_ack=1, m1_rdata=0. An m1 read of 0x7F0C (offset 3) returns 0 with no write strobe.
- Reset asserted during XFER of an m0 write:
  - No tX_we in the reset cycle and no ack.
  - State returns to IDLE and HWInt=0.
  - The held req is re-served after Reset drops.
- t1_irq rises at edge k: HWInt=6'b000010 from edge k+1. It clears one cycle after t1_irq falls, regardless of bus activity.
- m0 drops req the cycle after grant: m0_ack still pulses once, and no second transaction is started for m0.

Source files
------------

// File: rtl/timer_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_bus_arbiter
//  Purpose  : Shares the two timer register ports between two bus masters
//             (m0 = CPU load/store path, m1 = debug/DMA port). Requests are
//             arbitrated round-robin, each grant performs one register access
//             (IDLE -> XFER -> RESP) and the granted master receives a
//             one-cycle ack with registered read data. The timer IRQ lines
//             are registered into the HWInt vector for CP0.
//  Ports    : Clock, Reset        - rising-edge clock, synchronous active-high
//             mX_req/addr/we/wd   - master request (held until mX_ack)
//             mX_rdata/ack        - completion pulse and read data
//             tX_addr/we/wd       - timer register select / write strobe / data
//             tX_rd, tX_irq       - timer read data (combinational) and IRQ
//             HWInt[5:0]          - {4'b0, t1_irq, t0_irq}, one cycle late
//  Revision : 1.0 - initial release
// ============================================================================
module timer_bus_arbiter #(
   parameter logic [31:0] BASE0 = 32'h0000_7F00,
   parameter logic [31:0] BASE1 = 32'h0000_7F10
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [31:0] m0_wd,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [31:0] m1_wd,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic [1:0]  t0_addr,
   output logic        t0_we,
   output logic [31:0] t0_wd,
   input  logic [31:0] t0_rd,
   input  logic        t0_irq,
   output logic [1:0]  t1_addr,
   output logic        t1_we,
   output logic [31:0] t1_wd,
   input  logic [31:0] t1_rd,
   input  logic        t1_irq,
   output logic [5:0]  HWInt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic        last_grant;
   logic        grant_id;
   logic [31:2] lat_addr;       // byte lane bits are never used
   logic        lat_we;
   logic [31:0] lat_wd;
   logic [31:0] rdata_reg;

   logic        req_any;
   logic        pick;
   logic        hit0, hit1;
   logic [1:0]  offset;
   logic        offset_ok;
   logic [31:0] rd_sel;
   logic        in_xfer, in_resp;

   // addr[1:0] are ignored by design
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

   // Round-robin pick: on a tie the master not granted last wins.
   always_comb begin
      req_any = m0_req | m1_req;
      if (m0_req && m1_req) begin
         pick = ~last_grant;
      end else begin
         pick = m1_req;
      end
   end

   // Decode of the latched address; timer 0 takes precedence if the bases alias.
   assign hit0      = (lat_addr[31:4] == BASE0[31:4]);
   assign hit1      = (lat_addr[31:4] == BASE1[31:4]) && !hit0;
   assign offset    = lat_addr[3:2];
   assign offset_ok = (offset != 2'd3);

   always_comb begin
      rd_sel = 32'h0;
      if (hit0 && offset_ok) begin
         rd_sel = t0_rd;
      end else if (hit1 && offset_ok) begin
         rd_sel = t1_rd;
      end
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and outputs. Strobes and acks are masked while Reset
   // is high so an access interrupted by reset never reaches a timer.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      in_xfer    = 1'b0;
      in_resp    = 1'b0;
      t0_addr    = 2'd0;
      t0_we      = 1'b0;
      t0_wd      = 32'h0;
      t1_addr    = 2'd0;
      t1_we      = 1'b0;
      t1_wd      = 32'h0;
      m0_ack     = 1'b0;
      m1_ack     = 1'b0;
      m0_rdata   = 32'h0;
      m1_rdata   = 32'h0;

      case (state)
         IDLE: begin
            if (req_any) begin
               state_next = XFER;
            end
         end
         XFER: begin
            in_xfer    = !Reset;
            state_next = RESP;
         end
         RESP: begin
            in_resp    = !Reset;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (in_xfer && hit0) begin
         t0_addr = offset;
         t0_wd   = lat_wd;
         t0_we   = lat_we && offset_ok;
      end
      if (in_xfer && hit1) begin
         t1_addr = offset;
         t1_wd   = lat_wd;
         t1_we   = lat_we && offset_ok;
      end

      if (in_resp && !grant_id) begin
         m0_ack   = 1'b1;
         m0_rdata = rdata_reg;
      end
      if (in_resp && grant_id) begin
         m1_ack   = 1'b1;
         m1_rdata = rdata_reg;
      end
   end

   // ---------------------------------------------------------------------
   // Transaction latch, read-data capture, grant history and IRQ vector
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         last_grant <= 1'b1;     // master 0 wins the first tie
         grant_id   <= 1'b0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wd     <= 32'h0;
         rdata_reg  <= 32'h0;
         HWInt      <= 6'h0;
      end else begin
         HWInt <= {4'b0000, t1_irq, t0_irq};
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant_id <= pick;
                  lat_addr <= pick ? m1_addr[31:2] : m0_addr[31:2];
                  lat_we   <= pick ? m1_we : m0_we;
                  lat_wd   <= pick ? m1_wd : m0_wd;
               end
            end
            XFER: begin
               rdata_reg <= rd_sel;
            end
            RESP: begin
               last_grant <= grant_id;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_timer_bus_arbiter
//  Purpose  : Self-checking bench for timer_bus_arbiter. Two simple timer
//             register files sit on the timer ports; a transaction-level
//             reference (register contents + round-robin history) predicts
//             acks, read data, strobes and HWInt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bus_arbiter;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = 32'h0, m0_wd = 32'h0;
   logic [31:0] m0_rdata;
   logic        m0_ack;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = 32'h0, m1_wd = 32'h0;
   logic [31:0] m1_rdata;
   logic        m1_ack;
   logic [1:0]  t0_addr, t1_addr;
   logic        t0_we, t1_we;
   logic [31:0] t0_wd, t1_wd, t0_rd, t1_rd;
   logic        t0_irq = 1'b0, t1_irq = 1'b0;
   logic [5:0]  HWInt;

   int checks = 0;
   int errors = 0;

   timer_bus_arbiter dut (
      .Clock(Clock), .Reset(Reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .t0_addr(t0_addr), .t0_we(t0_we), .t0_wd(t0_wd), .t0_rd(t0_rd), .t0_irq(t0_irq),
      .t1_addr(t1_addr), .t1_we(t1_we), .t1_wd(t1_wd), .t1_rd(t1_rd), .t1_irq(t1_irq),
      .HWInt(HWInt)
   );

   always #5 Clock = ~Clock;

   // Timer register files: offsets 0..2 are real, offset 3 returns junk.
   logic [31:0] t0_mem [0:2];
   logic [31:0] t1_mem [0:2];
   initial begin
      for (int i = 0; i < 3; i++) begin
         t0_mem[i] <= 32'h0;
         t1_mem[i] <= 32'h0;
      end
   end
   always @(posedge Clock) begin
      if (t0_we && t0_addr != 2'd3) t0_mem[t0_addr] <= t0_wd;
      if (t1_we && t1_addr != 2'd3) t1_mem[t1_addr] <= t1_wd;
   end
   assign t0_rd = (t0_addr == 2'd3) ? 32'hBAD0_0003 : t0_mem[t0_addr];
   assign t1_rd = (t1_addr == 2'd3) ? 32'hBAD1_0003 : t1_mem[t1_addr];

   // Reference state: expected timer contents and who was granted last.
   logic [31:0] refm [0:1][0:2];
   int          lg_model = 1;

   initial begin
      for (int t = 0; t < 2; t++)
         for (int i = 0; i < 3; i++)
            refm[t][i] = 32'h0;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // 0 = timer 0, 1 = timer 1, 2 = unmapped
   function automatic int region(input logic [31:0] a);
      if ((a >> 4) == (32'h0000_7F00 >> 4)) return 0;
      if ((a >> 4) == (32'h0000_7F10 >> 4)) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] gen_addr(input int kind, input int off);
      logic [31:0] a;
      a = {30'h0, 2'($urandom_range(0, 3))} | (32'(off) << 2);
      if (kind == 0) return 32'h0000_7F00 | a;
      if (kind == 1) return 32'h0000_7F10 | a;
      return $urandom | 32'h8000_0000;
   endfunction

   // One arbitration round from IDLE: the requested masters are served in
   // round-robin order; the first ack is due 2 edges after the request, the
   // second 5 edges after it. Ends with the block back in IDLE.
   task automatic do_round(input bit r0, input bit r1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input bit w0, input bit w1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           output logic [31:0] rd0, output logic [31:0] rd1);
      logic [31:0] ad [2];
      logic [31:0] dv [2];
      bit          wv [2];
      logic [31:0] pend [2];
      int          order0, order1, nsrv, ncyc, xm, am, rg, o;
      logic [5:0]  exp_hw;
      logic [34:0] exp_t0, exp_t1;
      ad[0] = a0; ad[1] = a1; dv[0] = d0; dv[1] = d1; wv[0] = w0; wv[1] = w1;
      pend[0] = 32'h0; pend[1] = 32'h0;
      rd0 = 32'h0; rd1 = 32'h0;
      nsrv = int'(r0) + int'(r1);
      if (r0 && r1) order0 = (lg_model == 1) ? 0 : 1;
      else          order0 = r1 ? 1 : 0;
      order1 = 1 - order0;
      ncyc = (nsrv == 2) ? 6 : ((nsrv == 1) ? 3 : 2);
      m0_req = r0; m0_addr = a0; m0_we = w0; m0_wd = d0;
      m1_req = r1; m1_addr = a1; m1_we = w1; m1_wd = d1;
      for (int c = 1; c <= ncyc; c++) begin
         exp_hw = {4'b0000, t1_irq, t0_irq};
         tick();
         checks++;
         if (HWInt !== exp_hw) begin
            errors++;
            $display("FAIL round_hwint c=%0d: got %b expected %b", c, HWInt, exp_hw);
         end
         t0_irq = 1'($urandom); t1_irq = 1'($urandom);
         xm = -1; am = -1;
         if (nsrv >= 1 && c == 1) xm = order0;
         if (nsrv == 2 && c == 4) xm = order1;
         if (nsrv >= 1 && c == 2) am = order0;
         if (nsrv == 2 && c == 5) am = order1;
         exp_t0 = 35'h0; exp_t1 = 35'h0;
         if (xm >= 0) begin
            rg = region(ad[xm]);
            o  = int'(ad[xm][3:2]);
            if (rg == 0) exp_t0 = {wv[xm] && o != 3, 2'(o), dv[xm]};
            if (rg == 1) exp_t1 = {wv[xm] && o != 3, 2'(o), dv[xm]};
            if (rg < 2 && o != 3) begin
               pend[xm] = refm[rg][o];
               if (wv[xm]) refm[rg][o] = dv[xm];
            end
         end
         checks++;
         if ({t0_we, t0_addr, t0_wd} !== exp_t0 || {t1_we, t1_addr, t1_wd} !== exp_t1) begin
            errors++;
            $display("FAIL round_timer_port c=%0d: got t0=%h t1=%h expected t0=%h t1=%h",
                     c, {t0_we, t0_addr, t0_wd}, {t1_we, t1_addr, t1_wd}, exp_t0, exp_t1);
         end
         checks++;
         if (m0_ack !== (am == 0) || m1_ack !== (am == 1)) begin
            errors++;
            $display("FAIL round_ack c=%0d: got m0=%b m1=%b expected m0=%b m1=%b",
                     c, m0_ack, m1_ack, am == 0, am == 1);
         end
         checks++;
         if (m0_rdata !== ((am == 0) ? pend[0] : 32'h0) ||
             m1_rdata !== ((am == 1) ? pend[1] : 32'h0)) begin
            errors++;
            $display("FAIL round_rdata c=%0d: got m0=%h m1=%h expected m0=%h m1=%h", c,
                     m0_rdata, m1_rdata, (am == 0) ? pend[0] : 32'h0, (am == 1) ? pend[1] : 32'h0);
         end
         if (am == 0) begin rd0 = m0_rdata; m0_req = 1'b0; end
         if (am == 1) begin rd1 = m1_rdata; m1_req = 1'b0; end
         if (am >= 0) lg_model = am;
      end
      m0_req = 1'b0; m1_req = 1'b0; t0_irq = 1'b0; t1_irq = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; t0_irq = 1'b1; t1_irq = 1'b1;
      tick(); tick();
      checks++;
      if ({m0_ack, m1_ack, m0_rdata, m1_rdata, HWInt} !== 72'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b%b rd=%h/%h hw=%b expected all zero",
                  m0_ack, m1_ack, m0_rdata, m1_rdata, HWInt);
      end
      checks++;
      if ({t0_we, t1_we, t0_addr, t1_addr, t0_wd, t1_wd} !== 70'h0) begin
         errors++;
         $display("FAIL reset_timer_port: got we=%b%b expected 00", t0_we, t1_we);
      end
      Reset = 1'b0; t0_irq = 1'b0; t1_irq = 1'b0;
      lg_model = 1;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] r0, r1;
      do_round(1, 0, 32'h0000_7F04, 32'h0, 1, 0, 32'd100, 32'h0, r0, r1);
      do_round(1, 0, 32'h0000_7F04, 32'h0, 0, 0, 32'h0, 32'h0, r0, r1);
      checks++;
      if (r0 !== 32'd100) begin
         errors++;
         $display("FAIL write_read_back: got %0d expected 100", r0);
      end
   endtask

   task automatic test_arbitration();
      logic [31:0] r0, r1;
      bit e0, e1;
      do_round(1, 0, 32'h0000_7F00, 32'h0, 1, 0, 32'h1111_0000, 32'h0, r0, r1);
      do_round(0, 1, 32'h0, 32'h0000_7F18, 0, 1, 32'h0, 32'h2222_0002, r0, r1);
      Reset = 1'b1; tick(); Reset = 1'b0; lg_model = 1;
      m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_we = 1'b0;
      m1_req = 1'b1; m1_addr = 32'h0000_7F18; m1_we = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         e0 = (c == 2 || c == 8);
         e1 = (c == 5);
         checks++;
         if (m0_ack !== e0 || m1_ack !== e1) begin
            errors++;
            $display("FAIL arb_ack c=%0d: got m0=%b m1=%b expected m0=%b m1=%b",
                     c, m0_ack, m1_ack, e0, e1);
         end
         if (c == 2 || c == 5) begin
            checks++;
            if ((c == 2 && m0_rdata !== 32'h1111_0000) || (c == 5 && m1_rdata !== 32'h2222_0002)) begin
               errors++;
               $display("FAIL arb_rdata c=%0d: got m0=%h m1=%h", c, m0_rdata, m1_rdata);
            end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
      lg_model = 0;
   endtask

   task automatic test_unmapped();
      logic [31:0] r0, r1;
      do_round(0, 1, 32'h0, 32'h0000_7F20, 0, 1, 32'h0, 32'h0000_DEAD, r0, r1);
      checks++;
      if (r1 !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_write_rdata: got %h expected 0", r1);
      end
      do_round(0, 1, 32'h0, 32'h0000_7F0C, 0, 0, 32'h0, 32'h0, r0, r1);
      checks++;
      if (r1 !== 32'h0) begin
         errors++;
         $display("FAIL offset3_read: got %h expected 0", r1);
      end
   endtask

   task automatic test_reset_mid_xfer();
      m0_req = 1'b1; m0_addr = 32'h0000_7F08; m0_we = 1'b1; m0_wd = 32'hCAFE_0001;
      t0_irq = 1'b1; t1_irq = 1'b1;
      tick();
      checks++;
      if (t0_we !== 1'b1) begin
         errors++;
         $display("FAIL midxfer_pre_strobe: got %b expected 1", t0_we);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if ({t0_we, t1_we, m0_ack, m1_ack} !== 4'b0) begin
         errors++;
         $display("FAIL midxfer_reset_cycle: got we=%b%b ack=%b%b expected 0000",
                  t0_we, t1_we, m0_ack, m1_ack);
      end
      tick();
      checks++;
      if ({HWInt, m0_ack, t0_we} !== 8'h0) begin
         errors++;
         $display("FAIL midxfer_after_reset: got hw=%b ack=%b we=%b expected 0", HWInt, m0_ack, t0_we);
      end
      Reset = 1'b0; t0_irq = 1'b0; t1_irq = 1'b0; lg_model = 1;
      tick();
      checks++;
      if ({t0_we, t0_addr, t0_wd} !== {1'b1, 2'd2, 32'hCAFE_0001}) begin
         errors++;
         $display("FAIL midxfer_reserve_strobe: got we=%b addr=%0d wd=%h expected 1 2 cafe0001",
                  t0_we, t0_addr, t0_wd);
      end
      tick();
      checks++;
      if (m0_ack !== 1'b1 || m0_rdata !== refm[0][2]) begin
         errors++;
         $display("FAIL midxfer_reserve_ack: got ack=%b rd=%h expected 1 %h", m0_ack, m0_rdata, refm[0][2]);
      end
      m0_req = 1'b0;
      refm[0][2] = 32'hCAFE_0001;
      lg_model = 0;
      tick();
   endtask

   task automatic test_irq();
      t1_irq = 1'b1;
      tick();
      checks++;
      if (HWInt !== 6'b000010) begin
         errors++;
         $display("FAIL irq_rise: got %b expected 000010", HWInt);
      end
      tick();
      t1_irq = 1'b0;
      #1;
      checks++;
      if (HWInt !== 6'b000010) begin
         errors++;
         $display("FAIL irq_hold: got %b expected 000010", HWInt);
      end
      tick();
      checks++;
      if (HWInt !== 6'b000000) begin
         errors++;
         $display("FAIL irq_clear: got %b expected 000000", HWInt);
      end
   endtask

   task automatic test_req_drop();
      int acks;
      acks = 0;
      m0_req = 1'b1; m0_addr = 32'h0000_7F04; m0_we = 1'b1; m0_wd = 32'd77;
      tick();
      m0_req = 1'b0;
      tick();
      checks++;
      if (m0_ack !== 1'b1) begin
         errors++;
         $display("FAIL req_drop_ack: got %b expected 1", m0_ack);
      end
      refm[0][1] = 32'd77;
      lg_model = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         acks += int'(m0_ack) + int'(t0_we) + int'(t1_we);
      end
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL req_drop_no_repeat: got %0d extra events expected 0", acks);
      end
   endtask

   task automatic test_random();
      logic [31:0] r0, r1;
      for (int n = 0; n < 40; n++) begin
         do_round(1'($urandom), 1'($urandom),
                  gen_addr($urandom_range(0, 2), $urandom_range(0, 3)),
                  gen_addr($urandom_range(0, 2), $urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), $urandom, $urandom, r0, r1);
      end
      do_round(1, 0, 32'h0000_7F04, 32'h0, 0, 0, 32'h0, 32'h0, r0, r1);
      checks++;
      if (r0 !== refm[0][1]) begin
         errors++;
         $display("FAIL random_final_read: got %h expected %h", r0, refm[0][1]);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_arbitration();
      test_unmapped();
      test_reset_mid_xfer();
      test_irq();
      test_req_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
